// File: rtl/ppe_pkg.sv
// Shared types and helpers for the round-robin arbiter: state encoding,
// elaboration-time log2 and a one-hot to binary index converter.
package ppe_pkg;

    // Widest requester vector the index helper can take.
    localparam int MAX_W   = 4096;
    localparam int MAX_LOG = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // OR of the indices of all set bits; exact for a one-hot or zero vector.
    function automatic logic [MAX_LOG-1:0] onehot_to_idx(input logic [MAX_W-1:0] oh);
        logic [MAX_LOG-1:0] idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (oh[i]) idx |= MAX_LOG'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ppe_rr_arbiter_if.sv
// Request/grant bundle between the requester-side logic (master) and the
// round-robin arbiter (slave).
interface ppe_rr_arbiter_if
    import ppe_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int LOG_W = clog2(WIDTH)
);
    logic [WIDTH-1:0] Req;
    logic             Lock;
    logic             Ptr_load;
    logic [LOG_W-1:0] Ptr_val;
    logic [WIDTH-1:0] Gnt;
    logic [LOG_W-1:0] Gnt_idx;
    logic             Gnt_valid;
    logic             Gnt_ready;
    logic [LOG_W-1:0] Ptr;

    modport master (
        output Req, Lock, Ptr_load, Ptr_val, Gnt_ready,
        input  Gnt, Gnt_idx, Gnt_valid, Ptr
    );

    modport slave (
        input  Req, Lock, Ptr_load, Ptr_val, Gnt_ready,
        output Gnt, Gnt_idx, Gnt_valid, Ptr
    );
endinterface

// File: rtl/ppe_comb.sv
// Programmable priority encoder: lowest set request at or above ptr,
// wrapping to the lowest set request overall.
module ppe_comb
    import ppe_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int LOG_W = clog2(WIDTH)
)(
    input  logic [WIDTH-1:0] req,
    input  logic [LOG_W-1:0] ptr,
    output logic [WIDTH-1:0] win_oh,
    output logic [LOG_W-1:0] win_idx,
    output logic             any
);
    logic [WIDTH-1:0] therm;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] masked_oh;
    logic [WIDTH-1:0] req_oh;

    always_comb begin
        therm = '0;
        for (int i = 0; i < WIDTH; i++) begin
            therm[i] = (LOG_W'(i) >= ptr);
        end
    end

    assign masked = req & therm;

    // x & -x keeps only the lowest set bit.
    assign masked_oh = masked & (~masked + WIDTH'(1));
    assign req_oh    = req & (~req + WIDTH'(1));

    assign any     = |req;
    assign win_oh  = (|masked) ? masked_oh : req_oh;
    assign win_idx = LOG_W'(onehot_to_idx(MAX_W'(win_oh)));

endmodule

// File: rtl/ppe_rr_arbiter.sv
// Registered round-robin arbiter with valid/ready grant handshake, a
// rotating priority pointer and lock mode for multi-beat ownership.
module ppe_rr_arbiter
    import ppe_pkg::*;
#(
    parameter int               WIDTH   = 1024,
    parameter int               LOG_W   = clog2(WIDTH),
    parameter logic [LOG_W-1:0] PTR_RST = '0
)(
    input logic             clk,
    input logic             rst_n,
    ppe_rr_arbiter_if.slave bus
);
    state_e           state, state_nxt;
    logic [WIDTH-1:0] gnt, gnt_nxt;
    logic [LOG_W-1:0] gnt_idx, gnt_idx_nxt;
    logic             gnt_valid, gnt_valid_nxt;
    logic [LOG_W-1:0] ptr, ptr_nxt;

    logic             accept;
    logic             advance;
    logic [LOG_W-1:0] next_ptr;
    logic [LOG_W-1:0] sel_ptr;
    logic [WIDTH-1:0] win_oh;
    logic [LOG_W-1:0] win_idx;
    logic             win_any;

    assign accept   = gnt_valid & bus.Gnt_ready;
    assign advance  = (state == ST_OFFER) & accept & ~bus.Lock;
    // In LOCK, gnt_idx is the owner; wrap of WIDTH-1 to 0 is the natural overflow.
    assign next_ptr = gnt_idx + LOG_W'(1);

    // Selection uses the pointer that will be in force after this edge, so
    // a load or an advance shapes the back-to-back pick made alongside it.
    assign sel_ptr = bus.Ptr_load ? bus.Ptr_val :
                     advance      ? next_ptr    : ptr;

    ppe_comb #(.WIDTH(WIDTH), .LOG_W(LOG_W)) u_comb (
        .req     (bus.Req),
        .ptr     (sel_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    always_comb begin
        // NOTE: every *_nxt gets a default first so no path infers a latch.
        state_nxt     = state;
        gnt_nxt       = gnt;
        gnt_idx_nxt   = gnt_idx;
        gnt_valid_nxt = gnt_valid;
        ptr_nxt       = ptr;

        unique case (state)
            ST_IDLE: begin
                if (win_any) begin
                    gnt_nxt       = win_oh;
                    gnt_idx_nxt   = win_idx;
                    gnt_valid_nxt = 1'b1;
                    state_nxt     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (accept && bus.Lock) begin
                    state_nxt = ST_LOCK;
                end else if (accept) begin
                    ptr_nxt = next_ptr;
                    if (win_any) begin
                        gnt_nxt     = win_oh;
                        gnt_idx_nxt = win_idx;
                    end else begin
                        gnt_nxt       = '0;
                        gnt_idx_nxt   = '0;
                        gnt_valid_nxt = 1'b0;
                        state_nxt     = ST_IDLE;
                    end
                end
            end
            ST_LOCK: begin
                if (!bus.Req[gnt_idx]) begin
                    ptr_nxt       = next_ptr;
                    gnt_nxt       = '0;
                    gnt_idx_nxt   = '0;
                    gnt_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                gnt_nxt       = '0;
                gnt_idx_nxt   = '0;
                gnt_valid_nxt = 1'b0;
                state_nxt     = ST_IDLE;
            end
        endcase

        if (bus.Ptr_load) ptr_nxt = bus.Ptr_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= PTR_RST;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_valid <= gnt_valid_nxt;
            ptr       <= ptr_nxt;
        end
    end

    assign bus.Gnt       = gnt;
    assign bus.Gnt_idx   = gnt_idx;
    assign bus.Gnt_valid = gnt_valid;
    assign bus.Ptr       = ptr;

endmodule

// File: doc/ppe_rr_arbiter.md
Name: ppe_rr_arbiter

Overview:
- Registered round-robin arbiter built on programmable priority encoding; successor to the combinational encoder.
- Adds a stateful priority pointer that advances past each accepted winner, a valid/ready grant handshake and a lock mode for multi-cycle ownership.
- Sits between request-collection logic and a shared resource (output port, memory bank); one winner per accepted transfer.

Parameters:
- WIDTH, 1024, number of requesters; must be a power of two, >= 4.
- LOG_W, 10, log2(WIDTH); width of pointer and index fields.
- PTR_RST, 0, pointer value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Req  in  WIDTH  request vector, one bit per requester.
- Lock  in  1  sampled with an accepted grant; 1 = winner keeps ownership.
- Ptr_load  in  1  synchronous pointer override strobe.
- Ptr_val  in  LOG_W  value loaded into the pointer when Ptr_load=1.
- Gnt  out  WIDTH  registered one-hot grant; all zero when Gnt_valid=0.
- Gnt_idx  out  LOG_W  binary index of the Gnt bit.
- Gnt_valid  out  1  grant offered.
- Gnt_ready  in  1  consumer accepts the offered grant this cycle.
- Ptr  out  LOG_W  current priority pointer.

Behaviour:
- Reset (async, rst_n=0): Gnt=0, Gnt_idx=0, Gnt_valid=0, Ptr=PTR_RST, state=IDLE, lock owner cleared.
- Selection (combinational, inside ppe_comb):
  - Winner = lowest set index i >= Ptr in Req.
  - If none, winner = lowest set index overall (wrap).
  - no_req when Req==0.
- State IDLE: if Req!=0, register winner into Gnt/Gnt_idx and set Gnt_valid=1 next cycle; go to OFFER. Latency Req->Gnt_valid is 1 cycle.
- State OFFER: Gnt, Gnt_idx and Gnt_valid are held stable until Gnt_valid & Gnt_ready, even if Req changes or drops.
- On acceptance without Lock:
  - Ptr <= (Gnt_idx+1) mod WIDTH; index WIDTH-1 wraps to 0.
  - The next winner is selected the same cycle with the updated priority, so Gnt_valid stays 1 (back-to-back, 1 grant/cycle).
  - If no other request is eligible, the arbiter re-evaluates the current Req; if Req==0 it drops Gnt_valid and returns to IDLE.
- On acceptance with Lock=1: go to LOCK; Ptr is not advanced.
- State LOCK:
  - Gnt_valid=1 and Gnt holds the owner while Req[owner]=1; each acceptance is a further beat for the owner.
  - When Req[owner]=0 is seen, Gnt_valid drops for 1 cycle and Ptr <= owner+1. Next state is IDLE; normal arbitration resumes the following cycle.
- Ptr_load:
  - Takes effect at the next edge with highest priority over any pointer update in the same cycle.
  - Does not change a grant already offered; it affects the next selection only.
- Simultaneous acceptance and Ptr_load: grant completes; Ptr=Ptr_val.
- Invariants: Gnt is one-hot or zero; Gnt_idx==log2(Gnt) whenever Gnt_valid=1. No combinational path from Gnt_ready to Gnt.
- Reset mid-OFFER or mid-LOCK: outputs clear immediately (async) and the lock is released.

Decomposition:
- Package ppe_pkg holds:
  - the state encoding localparams (ST_IDLE, ST_OFFER, ST_LOCK, 2-bit);
  - a clog2 function;
  - a onehot-to-index function used by RTL and bench.
- Sub-module ppe_comb: purely combinational.
  - Inputs Req and Ptr.
  - Outputs winner one-hot, winner index and any.
  - Implementation: thermometer mask of Ptr, then two lowest-index priority encoders (masked and unmasked), masked result preferred.
- ppe_rr_arbiter holds the FSM, pointer, lock owner and output registers.

Test Plan:
- WIDTH=8, reset, Req=8'b1010_0100 held, Gnt_ready=1 -> Gnt_idx sequence 2,5,7,2,5; Ptr sequence 3,6,0,3,6.
- Gnt_ready=0 for 4 cycles with Req changing every cycle from 8'h10 -> Gnt=8'h10 and Gnt_idx=4 stable all 4 cycles; after ready, Ptr=5.
- Lock=1 on accept of idx 3, Req[3] held 3 more cycles with other bits set -> 4 grants to idx 3. Then Req[3]=0 -> one cycle Gnt_valid=0, Ptr=4, next winner is lowest set index >= 4.
- Ptr_load=1, Ptr_val=6, Req=8'b0100_0011 -> next winner idx 6; with Req=8'b0000_0011 -> wrap, winner idx 0.
- Ptr=7, Req=8'h80 accepted -> Ptr wraps to 0; Req=0 afterwards -> Gnt_valid=0, IDLE.
- rst_n asserted low mid-LOCK at an arbitrary phase (not on an edge) -> Gnt=0, Gnt_valid=0, Ptr=PTR_RST immediately; first grant after release follows reset priority.
